// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, layer record and scheduler state type
// Purpose: definitions shared by the VGA layer scheduler and its hit-test sub-module.
//   X_W/Y_W/RGB_W : pixel coordinate and colour widths
//   IDX_W         : width of a layer index (up to 8 layers)
//   layer_t       : one rectangle layer {x0,x1,y0,y1,rgb,en,blink}
//   sched_state_t : commit FSM states
package vga_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int RGB_W = 3;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [X_W-1:0]   x0;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y0;
    logic [Y_W-1:0]   y1;
    logic [RGB_W-1:0] rgb;
    logic             en;
    logic             blink;
  } layer_t;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/vga_rect_hit.sv
// rtl/vga_rect_hit.sv - combinational hit test of one rectangle layer
// Purpose: reports whether the current pixel lies inside an enabled layer.
// Ports:
//   pix_x_i, pix_y_i : current pixel
//   x0_i, x1_i       : column span, x0 <= x < x1
//   y0_i, y1_i       : row span, y0 <= y < y1
//   en_i             : layer enable
//   hit_o            : pixel is inside the layer (x0>=x1 or y0>=y1 never hits)
module vga_rect_hit
  import vga_pkg::*;
(
  input  logic [X_W-1:0] pix_x_i,
  input  logic [Y_W-1:0] pix_y_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [X_W-1:0] x1_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [Y_W-1:0] y1_i,
  input  logic           en_i,
  output logic           hit_o
);

  // Unsigned full-width compares; an inverted or zero-width span is empty by construction.
  assign hit_o = en_i &&
                 (pix_x_i >= x0_i) && (pix_x_i < x1_i) &&
                 (pix_y_i >= y0_i) && (pix_y_i < y1_i);

endmodule

// File: rtl/vga_layer_scheduler.sv
// rtl/vga_layer_scheduler.sv - prioritised rectangle layers with blanking-time commit
// Purpose: selects the pixel colour from N_LAYERS rectangle layers (index 0 wins).
//   Host writes go to shadow registers; a commit copies them into the active table
//   one layer per clk, started by frame_start when a write is pending.
// Optional feature: define LAYER_BLINK_EN to add a frame counter and per-layer blink.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   pix_clk, pix_x, pix_y       : pixel strobe and position
//   video_on, frame_start       : visible-area flag, start-of-blanking pulse
//   cfg_valid/cfg_ready         : host write handshake
//   cfg_idx, cfg_x0..cfg_y1     : target layer and its spans
//   cfg_rgb, cfg_en, cfg_blink  : layer colour, enable, blink flag
//   commit_done                 : one-clk pulse after the last layer is copied
//   r_out, g_out, b_out         : registered pixel colour
module vga_layer_scheduler
  import vga_pkg::*;
#(
  parameter int               N_LAYERS   = 4,
  parameter logic [RGB_W-1:0] BG_RGB     = 3'b000,
  parameter int               BLINK_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_clk,
  input  logic [X_W-1:0]   pix_x,
  input  logic [Y_W-1:0]   pix_y,
  input  logic             video_on,
  input  logic             frame_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [X_W-1:0]   cfg_x0,
  input  logic [X_W-1:0]   cfg_x1,
  input  logic [Y_W-1:0]   cfg_y0,
  input  logic [Y_W-1:0]   cfg_y1,
  input  logic [RGB_W-1:0] cfg_rgb,
  input  logic             cfg_en,
  input  logic             cfg_blink,
  output logic             commit_done,
  output logic             r_out,
  output logic             g_out,
  output logic             b_out
);

  localparam logic [IDX_W:0]   N_LIM    = N_LAYERS[IDX_W:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] cidx_q, cidx_d;
  logic             commit_done_q, commit_done_d;
  logic             dirty_q;
  logic             wr_fire, wr_hit, start_commit;
  logic             wr_blink, blink_hide;
  layer_t           wr_layer;
  layer_t           shadow_q [N_LAYERS];
  layer_t           active_q [N_LAYERS];
  logic [N_LAYERS-1:0] hit;
  logic [RGB_W-1:0] pix_rgb_d, rgb_q;

  assign cfg_ready   = (state_q == IDLE);
  assign commit_done = commit_done_q;
  assign wr_fire     = cfg_valid && cfg_ready;
  // Out-of-range indices still complete the handshake but touch nothing.
  assign wr_hit      = wr_fire && ({1'b0, cfg_idx} < N_LIM);

`ifdef LAYER_BLINK_EN
  logic [BLINK_LOG2-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      frame_cnt_q <= frame_cnt_q + BLINK_LOG2'(1);
    end
  end

  assign blink_hide = frame_cnt_q[BLINK_LOG2-1];
  assign wr_blink   = cfg_blink;
`else
  logic unused_blink;
  assign unused_blink = cfg_blink ^ BLINK_LOG2[0];
  assign blink_hide   = 1'b0;
  assign wr_blink     = 1'b0;
`endif

  always_comb begin
    wr_layer       = '0;
    wr_layer.x0    = cfg_x0;
    wr_layer.x1    = cfg_x1;
    wr_layer.y0    = cfg_y0;
    wr_layer.y1    = cfg_y1;
    wr_layer.rgb   = cfg_rgb;
    wr_layer.en    = cfg_en;
    wr_layer.blink = wr_blink;
  end

  // A write accepted alongside frame_start counts as pending, so it joins this commit.
  always_comb begin
    state_d       = state_q;
    cidx_d        = cidx_q;
    commit_done_d = 1'b0;
    start_commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start && (dirty_q || wr_hit)) begin
          state_d      = COMMIT;
          cidx_d       = '0;
          start_commit = 1'b1;
        end
      end
      COMMIT: begin
        if (cidx_q == LAST_IDX) begin
          state_d       = IDLE;
          commit_done_d = 1'b1;
        end else begin
          cidx_d = cidx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cidx_q        <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cidx_q        <= cidx_d;
      commit_done_q <= commit_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirty_q <= 1'b0;
      for (int i = 0; i < N_LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LAYERS; i++) begin
        if (wr_hit && (cfg_idx == IDX_W'(i))) shadow_q[i] <= wr_layer;
        if ((state_q == COMMIT) && (cidx_q == IDX_W'(i))) active_q[i] <= shadow_q[i];
      end
      if (start_commit) begin
        dirty_q <= 1'b0;
      end else if (wr_hit) begin
        dirty_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_LAYERS; g++) begin : g_layer
    logic hit_raw;
    vga_rect_hit u_hit (
      .pix_x_i (pix_x),
      .pix_y_i (pix_y),
      .x0_i    (active_q[g].x0),
      .x1_i    (active_q[g].x1),
      .y0_i    (active_q[g].y0),
      .y1_i    (active_q[g].y1),
      .en_i    (active_q[g].en),
      .hit_o   (hit_raw)
    );
    assign hit[g] = hit_raw && !(active_q[g].blink && blink_hide);
  end

  // Scan from the highest index down so the lowest-index hit is the last writer.
  always_comb begin
    pix_rgb_d = BG_RGB;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) pix_rgb_d = active_q[i].rgb;
    end
    if (!video_on) pix_rgb_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
    end else if (pix_clk) begin
      rgb_q <= pix_rgb_d;
    end
  end

  assign r_out = rgb_q[2];
  assign g_out = rgb_q[1];
  assign b_out = rgb_q[0];

endmodule
